// File: rtl/if_stage.sv
// Instruction fetch stage: PC register with redirect/stall control and the
// IF/ID pipeline register that feeds decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    input  logic        flush_i,
    output logic [31:0] inst_addr_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_inst_addr_o,
    output logic        if_valid_o,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        pc_d        = pc_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        misalign_d  = jump_en_i && (jump_addr_i[1:0] != 2'b00);

        // Redirect wins over stall; the low address bits are dropped, not trapped.
        if (jump_en_i) begin
            pc_d = {jump_addr_i[31:2], 2'b00};
        end else if (!hold_i) begin
            pc_d = pc_q + 32'd4;
        end

        // A redirect squashes the word fetched from the old path, like a flush.
        if (flush_i || jump_en_i) begin
            inst_d      = NOP_INST;
            inst_addr_d = 32'h0;
            valid_d     = 1'b0;
        end else if (!hold_i) begin
            inst_d      = inst_i;
            inst_addr_d = pc_q;
            valid_d     = 1'b1;
            cnt_d       = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            inst_addr_q <= 32'h0;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
            cnt_q       <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            valid_q     <= valid_d;
            misalign_q  <= misalign_d;
            cnt_q       <= cnt_d;
        end
    end

    assign inst_addr_o    = pc_q;
    assign if_inst_o      = inst_q;
    assign if_inst_addr_o = inst_addr_q;
    assign if_valid_o     = valid_q;
    assign misalign_o     = misalign_q;
    assign fetch_cnt_o    = cnt_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL provide parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), the bubble instruction.
REQ-003 The port list SHALL be:
- clk  input  1  the single clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- inst_i  input  32  instruction word returned combinationally by the instruction ROM for inst_addr_o.
- jump_en_i  input  1  redirect request from execute.
- jump_addr_i  input  32  redirect target byte address.
- hold_i  input  1  stall from downstream hazard logic.
- flush_i  input  1  squash the IF/ID contents.
- inst_addr_o  output  32  current PC; byte address driven to the ROM.
- if_inst_o  output  32  IF/ID latched instruction.
- if_inst_addr_o  output  32  PC of if_inst_o.
- if_valid_o  output  1  if_inst_o is a real fetched instruction, not a bubble.
- misalign_o  output  1  one-cycle pulse: a redirect target was not word-aligned.
- fetch_cnt_o  output  32  count of instructions captured into IF/ID.

Function
REQ-004 inst_addr_o SHALL be driven directly from the PC register, never combinationally from any input.
REQ-005 PC update priority SHALL be: jump_en_i, then hold_i, then sequential increment.
REQ-006 jump_en_i=1: PC SHALL load {jump_addr_i[31:2],2'b00} at the next edge, regardless of hold_i.
REQ-007 jump_en_i=1 with jump_addr_i[1:0]!=0: misalign_o SHALL be 1 for exactly the following cycle; otherwise misalign_o SHALL be 0.
REQ-008 jump_en_i=0, hold_i=1: PC SHALL keep its value.
REQ-009 jump_en_i=0, hold_i=0: PC SHALL become PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-010 IF/ID update priority SHALL be: (flush_i or jump_en_i), then hold_i, then capture.
REQ-011 Flush or jump: if_inst_o SHALL become NOP_INST, if_valid_o 0, if_inst_addr_o 32'h0.
REQ-012 Hold with no flush/jump: if_inst_o, if_inst_addr_o and if_valid_o SHALL keep their values.
REQ-013 Capture: if_inst_o SHALL become inst_i, if_inst_addr_o the current PC, if_valid_o 1.
REQ-014 Fetch latency SHALL be one cycle: the word at PC N appears on if_inst_o at the edge after inst_addr_o=N.
REQ-015 After a redirect, the first valid if_inst_o SHALL be the target word, two edges after the jump_en_i cycle. Exactly one bubble SHALL be inserted.
REQ-016 fetch_cnt_o SHALL increment by 1 on each capture edge (REQ-013 only), wrapping 32'hFFFF_FFFF to 0.
REQ-017 flush_i and hold_i together SHALL flush IF/ID and hold PC.

Reset
REQ-018 rst_n=0 SHALL, immediately and independently of clk, set:
- PC = RESET_PC
- if_inst_o = NOP_INST
- if_inst_addr_o = 0
- if_valid_o = 0
- misalign_o = 0
- fetch_cnt_o = 0
REQ-019 At the first rising edge with rst_n=1, the block SHALL capture the word at RESET_PC (if_valid_o=1) and advance PC to RESET_PC+4.
REQ-020 Reset asserted mid-stream SHALL discard any pending jump or hold; no misalign_o pulse SHALL survive reset.

Verification
REQ-021 Sequential fetch: ROM word[i]=i, release reset, 4 edges -> if_inst_o 0,1,2,3; if_inst_addr_o 0,4,8,12; fetch_cnt_o=4; inst_addr_o=16.
REQ-022 Jump: jump_en_i=1, jump_addr_i=32'h40 at PC=8 -> next cycle inst_addr_o=32'h40, if_valid_o=0, if_inst_o=32'h13; following cycle if_inst_o=word[16], if_inst_addr_o=32'h40.
REQ-023 Stall: hold_i=1 for 3 cycles at PC=12 -> inst_addr_o stays 12; if_inst_o unchanged; fetch_cnt_o unchanged; on release, fetch resumes at word[3].
REQ-024 Jump with hold plus misalignment: jump_en_i=1, hold_i=1, jump_addr_i=32'h22 -> PC=32'h20, misalign_o=1 for exactly one cycle, IF/ID bubble.
REQ-025 Wrap: RESET_PC=32'hFFFF_FFFC -> after two capture edges, inst_addr_o=32'h4; if_inst_addr_o=0.
REQ-026 Async reset: assert rst_n=0 between edges while valid -> outputs reach REQ-018 values before the next clk edge.
